// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for a single-port memory, with a read-return router.
// Latency: grant -> registered mem_en/addr next cycle; read accept -> rsp valid after RD_LAT+2 cycles.
// Backpressure: the losing port sees ready low and holds its request; responses cannot be stalled.
module mem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mux_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data
);

  // The tag pipe depth and alignment only make sense for latencies 1..8.
  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..8");
  end

  // last_grant_q: 0 = port 0 won most recently, 1 = port 1 won most recently.
  logic              last_grant_q;
  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [1:0]        mux_sel_q;
  logic [1:0]        mux_sel_d;

  // Tag pipe entry k is valid during the cycle k after the issue register loads,
  // so entry RD_LAT lines up with the cycle mem_rdata carries that read's data.
  logic [RD_LAT:0]   tag_vld_q;
  logic [RD_LAT:0]   tag_port_q;
  logic              tag_vld_d;
  logic              rsp_hit0;
  logic              rsp_hit1;

  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q;
  logic [DATA_W-1:0] rsp1_data_q;

  // Round-robin choice: a lone requester always wins; on a tie the port that did not win last goes.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || last_grant_q);
    gnt1       = req1_valid && (!req0_valid || !last_grant_q);
    gnt_any    = gnt0 || gnt1;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mux_sel_d  = 2'd0;
    if (gnt0) begin
      mem_we_d   = req0_we;
      mem_addr_d = req0_addr;
      mux_sel_d  = 2'd1;
    end else if (gnt1) begin
      mem_we_d   = req1_we;
      mem_addr_d = req1_addr;
      mux_sel_d  = 2'd2;
    end
    tag_vld_d  = gnt_any && !mem_we_d;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Issue register: drives the memory one cycle after the grant and remembers who won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mux_sel_q    <= 2'd0;
    end else begin
      mem_en_q   <= gnt_any;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mux_sel_q  <= mux_sel_d;
      if (gnt_any) begin
        last_grant_q <= gnt1;
      end
    end
  end

  // Tag pipe: entry 0 is captured alongside the issue register, then shifts once per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      tag_vld_q  <= {tag_vld_q[RD_LAT-1:0], tag_vld_d};
      tag_port_q <= {tag_port_q[RD_LAT-1:0], gnt1};
    end
  end

  assign rsp_hit0 = tag_vld_q[RD_LAT] && !tag_port_q[RD_LAT];
  assign rsp_hit1 = tag_vld_q[RD_LAT] && tag_port_q[RD_LAT];

  // Response registers: pulse valid for the tagged port only; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= rsp_hit0;
      rsp1_valid_q <= rsp_hit1;
      if (rsp_hit0) begin
        rsp0_data_q <= mem_rdata;
      end
      if (rsp_hit1) begin
        rsp1_data_q <= mem_rdata;
      end
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mux_sel    = mux_sel_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;

endmodule
